// File: rtl/toy_bus_fabric_if.sv
`default_nettype none
// ============================================================================
// Module   : toy_bus_fabric_if
// Brief    : CPU-side and slave-side signals of the toy bus fabric.
// Revision : 1.0 - initial release
// ============================================================================
interface toy_bus_fabric_if #(
    parameter int NSLAVES = 6
);
    logic                  i_req;
    logic [15:0]           i_addr;
    logic                  i_we;
    logic [15:0]           i_wdata;
    logic [15:0]           o_rdata;
    logic                  o_ready;
    logic [15:0]           o_addr;
    logic [15:0]           o_wdata;
    logic                  o_we;
    logic [NSLAVES-1:0]    o_sel;
    logic [NSLAVES*16-1:0] i_rdata;
    logic [NSLAVES-1:0]    i_slv_ready;
    logic                  o_fault_int;

    // Fabric view
    modport slave (
        input  i_req, i_addr, i_we, i_wdata, i_rdata, i_slv_ready,
        output o_rdata, o_ready, o_addr, o_wdata, o_we, o_sel, o_fault_int
    );

    // CPU and peripheral view
    modport master (
        output i_req, i_addr, i_we, i_wdata, i_rdata, i_slv_ready,
        input  o_rdata, o_ready, o_addr, o_wdata, o_we, o_sel, o_fault_int
    );
endinterface
`default_nettype wire

// File: rtl/toy_bus_fabric.sv
`default_nettype none
// ============================================================================
// Module   : toy_bus_fabric
// Brief    : Base/mask address decoder with wait states, timeout and fault block.
// Revision : 1.0 - initial release
// ============================================================================
module toy_bus_fabric #(
    parameter int                    NSLAVES     = 6,
    parameter logic [NSLAVES*16-1:0] BASE_ADDRS  = {16'h2000, 16'h0430, 16'h0420,
                                                    16'h0410, 16'h0400, 16'h0000},
    parameter logic [NSLAVES*16-1:0] ADDR_MASKS  = {16'hFC00, 16'hFFF0, 16'hFFF0,
                                                    16'hFFFE, 16'hFFFE, 16'hFC00},
    parameter logic [NSLAVES*4-1:0]  WAIT_CYCLES = {4'd1, 4'd0, 4'd0, 4'd0, 4'd0, 4'd1},
    parameter int                    TIMEOUT     = 15,
    parameter logic [15:0]           FAULT_BASE  = 16'h0440
) (
    input  wire logic       i_clk,
    input  wire logic       i_reset,
    toy_bus_fabric_if.slave bus
);

    localparam int         c_idx_w    = (NSLAVES > 1) ? $clog2(NSLAVES) : 1;
    localparam logic [7:0] c_tmo_last = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;

    logic [15:0]          r_addr;
    logic [15:0]          r_wdata;
    logic                 r_we;
    logic                 r_hit;
    logic                 r_fb;
    logic [c_idx_w-1:0]   r_idx;
    logic [NSLAVES-1:0]   r_sel;
    logic [3:0]           r_wcnt;
    logic [7:0]           r_tcnt;
    logic [15:0]          r_rdata;

    logic                 r_flt_valid;
    logic                 r_flt_type;
    logic                 r_flt_write;
    logic                 r_flt_ovf;
    logic [15:0]          r_flt_addr;

    logic                 w_dec_fb;
    logic                 w_dec_hit;
    logic [c_idx_w-1:0]   w_dec_idx;
    logic                 w_slv_rdy;
    logic [15:0]          w_slv_rdata;
    logic [15:0]          w_status;
    logic                 w_done;
    logic                 w_tmo;
    logic                 w_fin;
    logic                 w_fault;
    logic                 w_fb_clear;
    logic [15:0]          w_resp_data;
    logic                 w_ready;
    logic                 w_we;

    // Fault block overrides any window; scanning downwards lets the lowest index win
    always_comb begin
        w_dec_fb  = (bus.i_addr == FAULT_BASE) || (bus.i_addr == FAULT_BASE + 16'd1);
        w_dec_hit = 1'b0;
        w_dec_idx = '0;
        for (int k = NSLAVES - 1; k >= 0; k--) begin
            if ((bus.i_addr & ADDR_MASKS[16*k +: 16]) == BASE_ADDRS[16*k +: 16]) begin
                w_dec_hit = 1'b1;
                w_dec_idx = k[c_idx_w-1:0];
            end
        end
        if (w_dec_fb) begin
            w_dec_hit = 1'b0;
        end
    end

    assign w_slv_rdy   = bus.i_slv_ready[r_idx];
    assign w_slv_rdata = bus.i_rdata[{r_idx, 4'b0000} +: 16];
    assign w_status    = {12'h000, r_flt_ovf, r_flt_write, r_flt_type, r_flt_valid};

    // Non-slave accesses finish their single WAIT cycle at once, giving every
    // access the same two-cycle minimum latency.
    assign w_done     = (r_state == ST_WAIT) && (!r_hit || ((r_wcnt == 4'd0) && w_slv_rdy));
    assign w_tmo      = (r_state == ST_WAIT) && !w_done && (r_tcnt == c_tmo_last);
    assign w_fin      = w_done || w_tmo;
    assign w_fault    = (!r_hit && !r_fb) || w_tmo;
    assign w_fb_clear = r_fb && r_we && (r_addr == FAULT_BASE);

    always_comb begin
        w_resp_data = 16'h0000;
        if (!r_we) begin
            if (r_hit) begin
                w_resp_data = w_done ? w_slv_rdata : 16'h0000;
            end else if (r_fb) begin
                w_resp_data = (r_addr == FAULT_BASE) ? w_status : r_flt_addr;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ready     = 1'b0;
        w_we        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.i_req) begin
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (w_fin) begin
                    w_state_nxt = ST_RESP;
                end
                w_we = w_done && r_hit && r_we && !i_reset;
            end
            ST_RESP: begin
                w_state_nxt = ST_IDLE;
                w_ready     = !i_reset;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_addr      <= 16'h0000;
            r_wdata     <= 16'h0000;
            r_we        <= 1'b0;
            r_hit       <= 1'b0;
            r_fb        <= 1'b0;
            r_idx       <= '0;
            r_sel       <= '0;
            r_wcnt      <= 4'd0;
            r_tcnt      <= 8'd0;
            r_rdata     <= 16'h0000;
            r_flt_valid <= 1'b0;
            r_flt_type  <= 1'b0;
            r_flt_write <= 1'b0;
            r_flt_ovf   <= 1'b0;
            r_flt_addr  <= 16'h0000;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.i_req) begin
                        r_addr  <= bus.i_addr;
                        r_wdata <= bus.i_wdata;
                        r_we    <= bus.i_we;
                        r_hit   <= w_dec_hit;
                        r_fb    <= w_dec_fb;
                        r_idx   <= w_dec_idx;
                        r_sel   <= w_dec_hit ? (NSLAVES'(1) << w_dec_idx) : '0;
                        r_wcnt  <= w_dec_hit ? WAIT_CYCLES[{w_dec_idx, 2'b00} +: 4] : 4'd0;
                        r_tcnt  <= 8'd0;
                    end
                end
                ST_WAIT: begin
                    if (w_fin) begin
                        r_sel   <= '0;
                        r_rdata <= w_resp_data;
                        if (w_fb_clear) begin
                            r_flt_valid <= 1'b0;
                            r_flt_type  <= 1'b0;
                            r_flt_write <= 1'b0;
                            r_flt_ovf   <= 1'b0;
                        end else if (w_fault) begin
                            // Only the first fault is kept; later ones just flag overflow
                            if (!r_flt_valid) begin
                                r_flt_valid <= 1'b1;
                                r_flt_type  <= w_tmo;
                                r_flt_write <= r_we;
                                r_flt_addr  <= r_addr;
                            end else begin
                                r_flt_ovf   <= 1'b1;
                            end
                        end
                    end else begin
                        if (r_wcnt != 4'd0) begin
                            r_wcnt <= r_wcnt - 4'd1;
                        end
                        r_tcnt <= r_tcnt + 8'd1;
                    end
                end
                ST_RESP: begin
                    r_rdata <= 16'h0000;
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.o_ready     = w_ready;
    assign bus.o_we        = w_we;
    assign bus.o_rdata     = r_rdata;
    assign bus.o_addr      = r_addr;
    assign bus.o_wdata     = r_wdata;
    assign bus.o_sel       = r_sel;
    assign bus.o_fault_int = r_flt_valid;

endmodule
`default_nettype wire

// File: tb/tb_toy_bus_fabric.sv
`default_nettype none
// ============================================================================
// Module   : tb_toy_bus_fabric
// Brief    : Directed and randomized checks of toy_bus_fabric against a
//            cycle-timeline reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_toy_bus_fabric;
    localparam int NS  = 6;
    localparam int TMO = 15;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    toy_bus_fabric_if #(.NSLAVES(NS)) bus ();
    toy_bus_fabric #(.NSLAVES(NS)) dut (.i_clk(clk), .i_reset(rst), .bus(bus));

    logic [15:0] m_base [NS] = '{16'h0000, 16'h0400, 16'h0410, 16'h0420, 16'h0430, 16'h2000};
    logic [15:0] m_mask [NS] = '{16'hFC00, 16'hFFFE, 16'hFFFE, 16'hFFF0, 16'hFFF0, 16'hFC00};
    int          m_wait [NS] = '{1, 0, 0, 0, 0, 1};

    logic        m_fv, m_ft, m_fw, m_fo;
    logic [15:0] m_fa;
    logic [15:0] slv_data [NS];

    typedef struct {
        logic          rdy;
        logic [15:0]   rdata;
        logic [NS-1:0] sel;
        logic          we;
        logic          chk_bus;
        logic [15:0]   addr;
        logic [15:0]   wdata;
        logic          fint;
    } exp_t;
    exp_t exp_q [$];

    int          n_pass  = 0;
    int          n_total = 0;
    logic [15:0] last_rdata = 16'h0000;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Per-cycle compare against the expected timeline
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("ready", 32'(bus.o_ready), 32'(e.rdy));
            chk("sel", 32'(bus.o_sel), 32'(e.sel));
            chk("we", 32'(bus.o_we), 32'(e.we));
            chk("fault_int", 32'(bus.o_fault_int), 32'(e.fint));
            if (e.rdy) begin
                chk("rdata", 32'(bus.o_rdata), 32'(e.rdata));
                last_rdata = bus.o_rdata;
            end
            if (e.chk_bus) begin
                chk("addr", 32'(bus.o_addr), 32'(e.addr));
                chk("wdata", 32'(bus.o_wdata), 32'(e.wdata));
            end
        end
    end

    // Called just after a rising edge with the fabric idle; returns one cycle
    // after the response so the next request lands in IDLE.
    task automatic access(input logic [15:0] addr, input logic we, input logic [15:0] wdata,
                          input int lowcnt, input bit noisy);
        logic          fb, hit, tmo;
        int            idx, len, jc;
        logic [15:0]   rd;
        logic [NS-1:0] onehot;
        exp_t          e;
        fb  = (addr == 16'h0440) || (addr == 16'h0441);
        hit = 1'b0;
        idx = 0;
        for (int k = 0; k < NS; k++) begin
            if (!hit && !fb && ((addr & m_mask[k]) == m_base[k])) begin
                hit = 1'b1;
                idx = k;
            end
        end
        tmo = 1'b0;
        len = 2;
        if (hit) begin
            jc = (m_wait[idx] > lowcnt) ? m_wait[idx] + 1 : lowcnt + 1;
            if (jc > TMO) begin
                tmo = 1'b1;
                len = TMO + 1;
            end else begin
                len = jc + 1;
            end
        end
        rd = 16'h0000;
        if (!we && hit && !tmo) rd = slv_data[idx];
        else if (!we && fb) rd = (addr == 16'h0440) ? {12'h000, m_fo, m_fw, m_ft, m_fv} : m_fa;
        onehot = hit ? (NS'(1) << idx) : '0;
        for (int c = 0; c <= len; c++) begin
            if (c == len) begin
                if (fb && we && addr == 16'h0440) begin
                    {m_fv, m_ft, m_fw, m_fo} = 4'b0000;
                end else if ((!hit && !fb) || tmo) begin
                    if (!m_fv) begin
                        m_fv = 1'b1; m_ft = tmo; m_fw = we; m_fa = addr;
                    end else begin
                        m_fo = 1'b1;
                    end
                end
            end
            e.rdy     = (c == len);
            e.rdata   = rd;
            e.sel     = (c >= 1 && c < len) ? onehot : '0;
            e.we      = hit && we && !tmo && (c == len - 1);
            e.chk_bus = hit && (c >= 1) && (c < len);
            e.addr    = addr;
            e.wdata   = wdata;
            e.fint    = m_fv;
            exp_q.push_back(e);
        end
        for (int k = 0; k < NS; k++) bus.i_rdata[16*k +: 16] = slv_data[k];
        bus.i_req = 1'b1; bus.i_addr = addr; bus.i_we = we; bus.i_wdata = wdata;
        bus.i_slv_ready = '1;
        for (int c = 1; c <= len; c++) begin
            @(posedge clk); #1;
            if (noisy && c < len) begin
                bus.i_req = 1'($urandom_range(0, 1)); bus.i_addr = 16'($urandom);
                bus.i_we = 1'($urandom); bus.i_wdata = 16'($urandom);
            end else begin
                bus.i_req = 1'b0;
            end
            bus.i_slv_ready = noisy ? NS'($urandom) : '1;
            if (hit) bus.i_slv_ready[idx] = (c > lowcnt);
        end
        @(posedge clk); #1;
        bus.i_req = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ready"}, 32'(bus.o_ready), 32'd0);
        chk({tag, "_sel"}, 32'(bus.o_sel), 32'd0);
        chk({tag, "_we"}, 32'(bus.o_we), 32'd0);
        chk({tag, "_rdata"}, 32'(bus.o_rdata), 32'd0);
        chk({tag, "_addr"}, 32'(bus.o_addr), 32'd0);
        chk({tag, "_wdata"}, 32'(bus.o_wdata), 32'd0);
        chk({tag, "_fint"}, 32'(bus.o_fault_int), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_total);
        $fatal(1);
    end

    initial begin
        bus.i_req = 1'b0; bus.i_addr = 16'h0000; bus.i_we = 1'b0; bus.i_wdata = 16'h0000;
        bus.i_rdata = '0; bus.i_slv_ready = '1;
        {m_fv, m_ft, m_fw, m_fo} = 4'b0000; m_fa = 16'h0000;
        for (int k = 0; k < NS; k++) slv_data[k] = 16'h0000;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_all_zero("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        slv_data[0] = 16'h1234;
        access(16'h0010, 1'b0, 16'h5555, 0, 1'b0);
        chk("ram_read_lit", 32'(last_rdata), 32'h1234);
        access(16'h0400, 1'b1, 16'h00AB, 0, 1'b0);
        access(16'h1000, 1'b0, 16'h0000, 0, 1'b0);
        chk("unmapped_rdata_lit", 32'(last_rdata), 32'h0000);
        access(16'h0440, 1'b0, 16'h0000, 0, 1'b0);
        chk("status_unmapped_lit", 32'(last_rdata), 32'h0001);
        access(16'h0441, 1'b0, 16'h0000, 0, 1'b0);
        chk("fault_addr_lit", 32'(last_rdata), 32'h1000);
        chk("fault_int_lit", 32'(bus.o_fault_int), 32'd1);
        access(16'h0430, 1'b1, 16'h7777, 255, 1'b0);
        access(16'h0440, 1'b0, 16'h0000, 0, 1'b0);
        chk("status_overflow_lit", 32'(last_rdata), 32'h0009);
        access(16'h0440, 1'b1, 16'hFFFF, 0, 1'b0);
        access(16'h0440, 1'b0, 16'h0000, 0, 1'b0);
        chk("status_cleared_lit", 32'(last_rdata), 32'h0000);
        chk("fault_int_clear_lit", 32'(bus.o_fault_int), 32'd0);
        access(16'h0430, 1'b0, 16'h0000, 255, 1'b0);
        access(16'h0440, 1'b0, 16'h0000, 0, 1'b0);
        chk("status_timeout_lit", 32'(last_rdata), 32'h0003);

        // Reset lands on the cycle the RAM write would otherwise complete
        bus.i_req = 1'b1; bus.i_addr = 16'h0020; bus.i_we = 1'b1; bus.i_wdata = 16'hBEEF;
        bus.i_slv_ready = '0;
        @(posedge clk); #1;
        bus.i_req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        bus.i_slv_ready = '1;
        @(negedge clk);
        chk("rst_cycle_we", 32'(bus.o_we), 32'd0);
        chk("rst_cycle_ready", 32'(bus.o_ready), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        {m_fv, m_ft, m_fw, m_fo} = 4'b0000; m_fa = 16'h0000;
        @(negedge clk);
        chk_all_zero("post_reset");
        @(posedge clk); #1;
        slv_data[0] = 16'h4321;
        access(16'h0020, 1'b0, 16'h0000, 0, 1'b0);
        chk("post_reset_read_lit", 32'(last_rdata), 32'h4321);

        for (int n = 0; n < 300; n++) begin
            int          k, lc;
            logic [15:0] a;
            for (int j = 0; j < NS; j++) slv_data[j] = 16'($urandom);
            k = $urandom_range(0, NS - 1);
            case ($urandom_range(0, 5))
                0, 1:    a = m_base[k] | (16'($urandom) & ~m_mask[k]);
                2:       a = 16'h0440 | 16'($urandom_range(0, 1));
                3:       a = 16'h1000 | 16'($urandom_range(0, 16'h0FFF));
                default: a = 16'($urandom);
            endcase
            case ($urandom_range(0, 5))
                0:       lc = 0;
                1:       lc = 1;
                2:       lc = 2;
                3:       lc = 3;
                4:       lc = 14;
                default: lc = ($urandom_range(0, 3) == 0) ? 255 : 0;
            endcase
            access(a, 1'($urandom), 16'($urandom), lc, 1'b1);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
`default_nettype wire
